// File: rtl/dsp_t2_mac_lanes.sv
// Fracturable multiply-accumulate block: LANES independent MAC lanes, each with a
// pipelined multiplier, wrap-around accumulator and shift/round/saturate output stage.
module dsp_t2_mac_lanes #(
    parameter int LANES           = 1,
    parameter int A_WIDTH         = 20,
    parameter int B_WIDTH         = 18,
    parameter int ACC_WIDTH       = 64,
    parameter int Z_WIDTH         = 38,
    parameter int REGISTER_INPUTS = 0
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic [LANES*A_WIDTH-1:0]   a_i,
    input  logic [LANES*B_WIDTH-1:0]   b_i,
    input  logic                       unsigned_a_i,
    input  logic                       unsigned_b_i,
    input  logic                       load_acc_i,
    input  logic                       subtract_i,
    input  logic [1:0]                 output_select_i,
    input  logic [5:0]                 shift_right_i,
    input  logic                       round_i,
    input  logic                       saturate_enable_i,
    output logic                       valid_o,
    output logic [LANES*Z_WIDTH-1:0]   z_o,
    output logic [LANES*B_WIDTH-1:0]   dly_b_o,
    output logic [LANES-1:0]           sat_o
);

    typedef struct packed {
        logic       uns_a;
        logic       uns_b;
        logic       load;
        logic       sub;
        logic [1:0] sel;
        logic [5:0] sh;
        logic       rnd;
        logic       sat_en;
    } ctrl_t;

    typedef struct packed {
        logic       uns;
        logic       load;
        logic [1:0] sel;
        logic [5:0] sh;
        logic       rnd;
        logic       sat_en;
    } out_ctrl_t;

    // Operands are sign- or zero-extended to the accumulator width so the low product bits wrap correctly.
    function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [A_WIDTH-1:0] a,
                                                     input logic [B_WIDTH-1:0] b,
                                                     input logic ua, input logic ub);
        logic [ACC_WIDTH-1:0] ax;
        logic [ACC_WIDTH-1:0] bx;
        ax = {{(ACC_WIDTH-A_WIDTH){a[A_WIDTH-1] & ~ua}}, a};
        bx = {{(ACC_WIDTH-B_WIDTH){b[B_WIDTH-1] & ~ub}}, b};
        return ax * bx;
    endfunction

    function automatic logic [ACC_WIDTH-1:0] acc_next(input logic [ACC_WIDTH-1:0] acc,
                                                      input logic [ACC_WIDTH-1:0] p,
                                                      input logic load, input logic sub);
        logic [ACC_WIDTH-1:0] base;
        base = load ? {ACC_WIDTH{1'b0}} : acc;
        return sub ? (base - p) : (base + p);
    endfunction

    // Returns {clamped, z}: bias, shift in ACC_WIDTH+1 bits, then saturate or truncate.
    function automatic logic [Z_WIDTH:0] post_proc(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic uns, input logic [5:0] sh,
                                                   input logic rnd, input logic sat_en);
        logic [ACC_WIDTH:0]   one;
        logic [ACC_WIDTH:0]   bias;
        logic [ACC_WIDTH:0]   t;
        logic [ACC_WIDTH:0]   r;
        logic                 ovf;
        logic [Z_WIDTH-1:0]   z;
        one  = {{ACC_WIDTH{1'b0}}, 1'b1};
        bias = (rnd && (sh != 6'd0)) ? (one << (sh - 6'd1)) : {(ACC_WIDTH+1){1'b0}};
        t    = {acc[ACC_WIDTH-1] & ~uns, acc} + bias;
        if (uns) begin
            r   = t >> sh;
            ovf = |r[ACC_WIDTH:Z_WIDTH];
        end else begin
            r   = $signed(t) >>> sh;
            ovf = !((&r[ACC_WIDTH:Z_WIDTH-1]) || !(|r[ACC_WIDTH:Z_WIDTH-1]));
        end
        if (sat_en && ovf) begin
            if (uns) begin
                z = {Z_WIDTH{1'b1}};
            end else if (r[ACC_WIDTH]) begin
                z = {1'b1, {(Z_WIDTH-1){1'b0}}};
            end else begin
                z = {1'b0, {(Z_WIDTH-1){1'b1}}};
            end
        end else begin
            z = r[Z_WIDTH-1:0];
        end
        return {sat_en & ovf, z};
    endfunction

    ctrl_t                          ctrl_in_s;
    logic                           v0_s;
    logic [LANES*A_WIDTH-1:0]       a0_s;
    logic [LANES*B_WIDTH-1:0]       b0_s;
    ctrl_t                          c0_s;

    assign ctrl_in_s = {unsigned_a_i, unsigned_b_i, load_acc_i, subtract_i, output_select_i,
                        shift_right_i, round_i, saturate_enable_i};

    generate
        if (REGISTER_INPUTS != 0) begin : g_in_reg
            logic                     v_r;
            logic [LANES*A_WIDTH-1:0] a_r;
            logic [LANES*B_WIDTH-1:0] b_r;
            ctrl_t                    c_r;

            // Optional input register stage.
            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    v_r <= 1'b0;
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= '0;
                end else begin
                    v_r <= valid_i;
                    if (valid_i) begin
                        a_r <= a_i;
                        b_r <= b_i;
                        c_r <= ctrl_in_s;
                    end
                end
            end

            assign v0_s = v_r;
            assign a0_s = a_r;
            assign b0_s = b_r;
            assign c0_s = c_r;
        end else begin : g_in_comb
            assign v0_s = valid_i;
            assign a0_s = a_i;
            assign b0_s = b_i;
            assign c0_s = ctrl_in_s;
        end
    endgenerate

    logic                                v1_r;
    ctrl_t                               c1_r;
    logic [LANES-1:0][ACC_WIDTH-1:0]     p1_r;

    // S1: product register.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            v1_r <= 1'b0;
            c1_r <= '0;
            p1_r <= '0;
        end else begin
            v1_r <= v0_s;
            if (v0_s) begin
                c1_r <= c0_s;
                for (int k = 0; k < LANES; k++) begin
                    p1_r[k] <= mul_ext(a0_s[k*A_WIDTH +: A_WIDTH], b0_s[k*B_WIDTH +: B_WIDTH],
                                       c0_s.uns_a, c0_s.uns_b);
                end
            end
        end
    end

    logic                                v2_r;
    out_ctrl_t                           c2_r;
    logic [LANES-1:0][ACC_WIDTH-1:0]     acc_r;
    logic [LANES-1:0][Z_WIDTH-1:0]       p2_r;

    // S2: accumulator; the product rides alongside for output select 0.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            v2_r  <= 1'b0;
            c2_r  <= '0;
            acc_r <= '0;
            p2_r  <= '0;
        end else begin
            v2_r <= v1_r;
            if (v1_r) begin
                c2_r <= {c1_r.uns_a & c1_r.uns_b, c1_r.load, c1_r.sel, c1_r.sh, c1_r.rnd, c1_r.sat_en};
                for (int k = 0; k < LANES; k++) begin
                    acc_r[k] <= acc_next(acc_r[k], p1_r[k], c1_r.load, c1_r.sub);
                    p2_r[k]  <= p1_r[k][Z_WIDTH-1:0];
                end
            end
        end
    end

    logic [LANES-1:0][Z_WIDTH:0]   pp_s;
    logic [LANES*Z_WIDTH-1:0]      z_nxt_s;
    logic [LANES-1:0]              clamp_s;

    // Output selection per lane.
    always_comb begin
        pp_s    = '0;
        z_nxt_s = '0;
        clamp_s = '0;
        for (int k = 0; k < LANES; k++) begin
            pp_s[k] = post_proc(acc_r[k], c2_r.uns, c2_r.sh, c2_r.rnd, c2_r.sat_en);
            case (c2_r.sel)
                2'd0: z_nxt_s[k*Z_WIDTH +: Z_WIDTH] = p2_r[k];
                2'd1: begin
                    z_nxt_s[k*Z_WIDTH +: Z_WIDTH] = pp_s[k][Z_WIDTH-1:0];
                    clamp_s[k]                    = pp_s[k][Z_WIDTH];
                end
                2'd2: z_nxt_s[k*Z_WIDTH +: Z_WIDTH] = acc_r[k][Z_WIDTH-1:0];
                default: z_nxt_s[k*Z_WIDTH +: Z_WIDTH] = {Z_WIDTH{1'b0}};
            endcase
        end
    end

    // S3: output register and sticky saturation flags; bubbles hold the last result.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_o <= 1'b0;
            z_o     <= '0;
            sat_o   <= '0;
        end else begin
            valid_o <= v2_r;
            if (v2_r) begin
                z_o <= z_nxt_s;
                for (int k = 0; k < LANES; k++) begin
                    if (clamp_s[k]) begin
                        sat_o[k] <= 1'b1;
                    end else if (c2_r.load) begin
                        sat_o[k] <= 1'b0;
                    end
                end
            end
        end
    end

    // b is echoed from the raw input one cycle later, only for valid samples.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            dly_b_o <= '0;
        end else if (valid_i) begin
            dly_b_o <= b_i;
        end
    end

endmodule

// File: tb/tb_dsp_t2_mac_lanes.sv
// Self-checking bench for dsp_t2_mac_lanes: directed scenarios plus randomized traffic
// against an arithmetic reference model (2 lanes, 10x9, 40-bit acc, 16-bit output).
module tb_dsp_t2_mac_lanes;

    localparam longint M40 = 64'h00FF_FFFF_FFFF;
    localparam longint M41 = 64'h01FF_FFFF_FFFF;
    localparam longint P40 = 64'h0100_0000_0000;
    localparam longint P41 = 64'h0200_0000_0000;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic [19:0] a_i;
    logic [17:0] b_i;
    logic        unsigned_a_i, unsigned_b_i, load_acc_i, subtract_i;
    logic [1:0]  output_select_i;
    logic [5:0]  shift_right_i;
    logic        round_i, saturate_enable_i;
    logic        valid_o;
    logic [31:0] z_o;
    logic [17:0] dly_b_o;
    logic [1:0]  sat_o;

    dsp_t2_mac_lanes #(
        .LANES(2), .A_WIDTH(10), .B_WIDTH(9), .ACC_WIDTH(40), .Z_WIDTH(16), .REGISTER_INPUTS(0)
    ) dut (
        .clock_i(clock_i), .reset_i(reset_i), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
        .unsigned_a_i(unsigned_a_i), .unsigned_b_i(unsigned_b_i), .load_acc_i(load_acc_i),
        .subtract_i(subtract_i), .output_select_i(output_select_i), .shift_right_i(shift_right_i),
        .round_i(round_i), .saturate_enable_i(saturate_enable_i), .valid_o(valid_o), .z_o(z_o),
        .dly_b_o(dly_b_o), .sat_o(sat_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        int          due;
        logic [31:0] z;
        logic [1:0]  clamp;
        logic        ld;
    } rec_t;

    rec_t        q[$];
    longint      macc[2];
    logic        exp_valid;
    logic [31:0] exp_z;
    logic [1:0]  exp_sat;
    logic [17:0] exp_dly;
    int          edges = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic model_clear();
        q.delete();
        macc[0] = 0;
        macc[1] = 0;
        exp_valid = 1'b0;
        exp_z = '0;
        exp_sat = '0;
        exp_dly = '0;
    endtask

    // Reference: evaluate the sample arithmetically at issue, release it three edges later.
    task automatic tick();
        rec_t        r;
        logic [9:0]  ak;
        logic [8:0]  bk;
        longint      av, bv, p, accv, rnd, t, rr;
        logic [15:0] zk;
        logic        uns;
        int          shv;
        if (valid_i) begin
            r.due = edges + 3; r.ld = load_acc_i; r.clamp = '0; r.z = '0;
            uns = unsigned_a_i & unsigned_b_i;
            shv = int'(shift_right_i);
            for (int k = 0; k < 2; k++) begin
                ak = a_i[k*10 +: 10];
                bk = b_i[k*9 +: 9];
                av = unsigned_a_i ? longint'(ak) : longint'($signed(ak));
                bv = unsigned_b_i ? longint'(bk) : longint'($signed(bk));
                p  = av * bv;
                if (load_acc_i) macc[k] = subtract_i ? -p : p;
                else            macc[k] = subtract_i ? macc[k] - p : macc[k] + p;
                macc[k] = macc[k] & M40;
                zk = '0;
                case (output_select_i)
                    2'd0: zk = p[15:0];
                    2'd2: zk = macc[k][15:0];
                    2'd3: zk = '0;
                    default: begin
                        accv = (!uns && macc[k][39]) ? macc[k] - P40 : macc[k];
                        rnd  = (round_i && shv != 0) ? ((longint'(64'd1) << (shv - 1)) & M41) : 0;
                        t    = (accv + rnd) & M41;
                        if (!uns && t[40]) t = t - P41;
                        rr   = uns ? (t >> shv) : (t >>> shv);
                        zk   = rr[15:0];
                        if (saturate_enable_i) begin
                            if (uns && rr > 65535) begin zk = 16'hFFFF; r.clamp[k] = 1'b1; end
                            if (!uns && rr > 32767) begin zk = 16'h7FFF; r.clamp[k] = 1'b1; end
                            if (!uns && rr < -32768) begin zk = 16'h8000; r.clamp[k] = 1'b1; end
                        end
                    end
                endcase
                r.z[k*16 +: 16] = zk;
            end
            q.push_back(r);
            exp_dly = b_i;
        end
        @(posedge clock_i);
        edges++;
        #1;
        exp_valid = 1'b0;
        if (q.size() > 0 && q[0].due == edges) begin
            r = q.pop_front();
            exp_valid = 1'b1;
            exp_z = r.z;
            for (int k = 0; k < 2; k++) begin
                if (r.clamp[k]) exp_sat[k] = 1'b1;
                else if (r.ld)  exp_sat[k] = 1'b0;
            end
        end
    endtask

    task automatic set_in(input logic v, input logic [9:0] a0, input logic [8:0] b0,
                          input logic [9:0] a1, input logic [8:0] b1, input logic ld,
                          input logic sub, input logic [1:0] sel, input logic [5:0] sh,
                          input logic rnd, input logic sat, input logic ua, input logic ub);
        valid_i = v; a_i = {a1, a0}; b_i = {b1, b0};
        load_acc_i = ld; subtract_i = sub; output_select_i = sel; shift_right_i = sh;
        round_i = rnd; saturate_enable_i = sat; unsigned_a_i = ua; unsigned_b_i = ub;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_i = 1'b0;
        #2;
        model_clear();
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_vec += 4;
        if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", valid_o); end
        if (z_o !== 32'd0) begin n_err++; $display("FAIL reset_z: got %h, expected 0", z_o); end
        if (sat_o !== 2'd0) begin n_err++; $display("FAIL reset_sat: got %b, expected 0", sat_o); end
        if (dly_b_o !== 18'd0) begin n_err++; $display("FAIL reset_dly: got %h, expected 0", dly_b_o); end
        reset_i = 1'b1;
        #4;
    endtask

    task automatic test_signed_basic();
        do_reset();
        set_in(1'b1, -10'sd3, 9'd5, 10'd0, 9'd0, 1'b1, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            valid_i = 1'b0;
            n_vec++;
            if (valid_o !== (i == 2)) begin
                n_err++; $display("FAIL basic_valid[%0d]: got %b, expected %b", i, valid_o, (i == 2));
            end
            if (i >= 2) begin
                n_vec++;
                if (z_o !== 32'h0000_FFF1) begin
                    n_err++; $display("FAIL basic_z[%0d]: got %h, expected 0000fff1", i, z_o);
                end
            end
        end
    endtask

    task automatic test_accumulate();
        logic [15:0] e0, e1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_in(1'b1, 10'd100, 9'd100, -10'sd7, 9'd3, (i == 0), 1'b0, 2'd1, 6'd0,
                              1'b0, 1'b0, 1'b0, 1'b0);
            else valid_i = 1'b0;
            tick();
            if (i >= 2) begin
                e0 = 16'((i - 1) * 10000);
                e1 = 16'(-(i - 1) * 21);
                n_vec += 2;
                if (valid_o !== 1'b1) begin n_err++; $display("FAIL acc_valid[%0d]: got %b, expected 1", i, valid_o); end
                if (z_o !== {e1, e0}) begin n_err++; $display("FAIL acc_z[%0d]: got %h, expected %h", i, z_o, {e1, e0}); end
            end
        end
    endtask

    task automatic test_round_shift();
        logic [9:0]  a0s[3] = '{10'h017, 10'h018, 10'h018};
        logic [9:0]  a1s[3] = '{10'h3E9, 10'h3E8, 10'h3E8};
        logic        rs[3]  = '{1'b1, 1'b1, 1'b0};
        logic [31:0] ez[3]  = '{32'hFFFF_0001, 32'hFFFF_0002, 32'hFFFE_0001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_in(1'b1, a0s[i], 9'd1, a1s[i], 9'd1, 1'b1, 1'b0, 2'd1, 6'd4, rs[i],
                              1'b0, 1'b0, 1'b0);
            else valid_i = 1'b0;
            tick();
            if (i >= 2) begin
                n_vec++;
                if (z_o !== ez[i-2]) begin n_err++; $display("FAIL round_z[%0d]: got %h, expected %h", i - 2, z_o, ez[i-2]); end
            end
        end
    endtask

    task automatic test_saturate();
        logic [9:0]  a0s[4] = '{10'd200, 10'd0, 10'd1, 10'd1023};
        logic [8:0]  b0s[4] = '{9'd200, 9'd0, 9'd1, 9'd511};
        logic [9:0]  a1s[4] = '{10'h338, 10'd0, 10'h3FF, 10'd2};
        logic [8:0]  b1s[4] = '{9'd200, 9'd0, 9'd1, 9'd3};
        logic        lds[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [1:0]  sls[4] = '{2'd1, 2'd2, 2'd1, 2'd1};
        logic        sts[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        uns[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ez[4]  = '{32'h8000_7FFF, 32'h63C0_9C40, 32'hFFFF_0001, 32'h0006_FFFF};
        logic [1:0]  es[4]  = '{2'b11, 2'b11, 2'b00, 2'b01};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) set_in(1'b1, a0s[i], b0s[i], a1s[i], b1s[i], lds[i], 1'b0, sls[i], 6'd0,
                              1'b0, sts[i], uns[i], uns[i]);
            else valid_i = 1'b0;
            tick();
            if (i >= 2) begin
                n_vec += 2;
                if (z_o !== ez[i-2]) begin n_err++; $display("FAIL sat_z[%0d]: got %h, expected %h", i - 2, z_o, ez[i-2]); end
                if (sat_o !== es[i-2]) begin n_err++; $display("FAIL sat_flag[%0d]: got %b, expected %b", i - 2, sat_o, es[i-2]); end
            end
        end
    endtask

    task automatic test_lanes_independent();
        logic [8:0]  b0s[3] = '{9'h100, 9'h100, 9'd7};
        logic [8:0]  b1s[3] = '{9'd255, 9'd255, 9'd9};
        logic [1:0]  sls[3] = '{2'd1, 2'd0, 2'd3};
        logic [31:0] ez[3]  = '{32'h0200_0100, 32'h0200_0100, 32'h0000_0000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_in(1'b1, 10'd511, b0s[i], 10'h200, b1s[i], (i == 0), 1'b0, sls[i], 6'd0,
                              1'b0, 1'b0, 1'b0, 1'b0);
            else begin valid_i = 1'b0; b_i = 18'h2A5A5; end
            tick();
            n_vec++;
            if (dly_b_o !== {b1s[(i < 3) ? i : 2], b0s[(i < 3) ? i : 2]}) begin
                n_err++; $display("FAIL lanes_dly[%0d]: got %h, expected %h", i, dly_b_o,
                                  {b1s[(i < 3) ? i : 2], b0s[(i < 3) ? i : 2]});
            end
            if (i >= 2) begin
                n_vec++;
                if (z_o !== ez[i-2]) begin n_err++; $display("FAIL lanes_z[%0d]: got %h, expected %h", i - 2, z_o, ez[i-2]); end
            end
        end
    endtask

    task automatic test_bubbles_and_reset();
        logic [15:0] e0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || i == 4) set_in(1'b1, 10'd100, 9'd100, 10'd100, 9'd100, (i == 0), 1'b0,
                                         2'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            else valid_i = 1'b0;
            tick();
            e0 = (i < 2) ? 16'd0 : ((i < 6) ? 16'd10000 : 16'd20000);
            n_vec += 2;
            if (valid_o !== (i == 2 || i == 6)) begin
                n_err++; $display("FAIL gap_valid[%0d]: got %b, expected %b", i, valid_o, (i == 2 || i == 6));
            end
            if (z_o !== {e0, e0}) begin n_err++; $display("FAIL gap_z[%0d]: got %h, expected %h", i, z_o, {e0, e0}); end
        end
        set_in(1'b1, 10'd5, 9'd7, 10'd9, 9'd11, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        model_clear();
        n_vec += 4;
        if (valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b, expected 0", valid_o); end
        if (z_o !== 32'd0) begin n_err++; $display("FAIL midrst_z: got %h, expected 0", z_o); end
        if (sat_o !== 2'd0) begin n_err++; $display("FAIL midrst_sat: got %b, expected 0", sat_o); end
        if (dly_b_o !== 18'd0) begin n_err++; $display("FAIL midrst_dly: got %h, expected 0", dly_b_o); end
        reset_i = 1'b1;
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (valid_o !== 1'b0 || z_o !== 32'd0) begin
                n_err++; $display("FAIL midrst_flush[%0d]: got valid=%b z=%h, expected valid=0 z=0", i, valid_o, z_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(3) != 0, 10'($urandom()), 9'($urandom()), 10'($urandom()),
                   9'($urandom()), $urandom_range(3) == 0, 1'($urandom()), 2'($urandom()),
                   ($urandom_range(1) == 0) ? 6'($urandom_range(20)) : 6'($urandom()),
                   1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()));
            if ($urandom_range(149) == 0) begin
                reset_i = 1'b0;
                #1;
                model_clear();
                reset_i = 1'b1;
            end
            tick();
            n_vec += 4;
            if (valid_o !== exp_valid) begin n_err++; $display("FAIL rand_valid[%0d]: got %b, expected %b", i, valid_o, exp_valid); end
            if (z_o !== exp_z) begin n_err++; $display("FAIL rand_z[%0d]: got %h, expected %h", i, z_o, exp_z); end
            if (sat_o !== exp_sat) begin n_err++; $display("FAIL rand_sat[%0d]: got %b, expected %b", i, sat_o, exp_sat); end
            if (dly_b_o !== exp_dly) begin n_err++; $display("FAIL rand_dly[%0d]: got %h, expected %h", i, dly_b_o, exp_dly); end
        end
    endtask

    initial begin
        reset_i = 1'b0;
        set_in(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_clear();
        test_reset();
        test_signed_basic();
        test_accumulate();
        test_round_shift();
        test_saturate();
        test_lanes_independent();
        test_bubbles_and_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
